// File: rtl/rr_arb_16x1.sv
// Round-robin arbiter steering a shared 16x1 beat mux, with per-grant beat limit
// and back-to-back re-arbitration on release.
module rr_arb_16x1 #(
    parameter int unsigned MAX_BEATS = 16,
    parameter int unsigned W         = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] req_valid_i,
    input  logic [15:0] req_last_i,
    input  logic [15:0] req_mask_i,
    input  logic        out_ready_i,
    output logic [15:0] req_ready_o,
    output logic [3:0]  sel_o,
    output logic        out_valid_o,
    output logic        out_last_o,
    output logic        busy_o
);

    if (MAX_BEATS < 1 || MAX_BEATS > 256 || W < 1) begin : g_param_check
        $error("rr_arb_16x1: MAX_BEATS must be 1..256 and W >= 1");
    end

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [7:0] LAST_BEAT = 8'(MAX_BEATS - 1);

    state_t      state_q, state_d;
    logic [3:0]  g_q, g_d;
    logic [3:0]  p_q, p_d;
    logic [7:0]  c_q, c_d;
    logic [15:0] elig;
    logic [15:0] elig_rel;
    logic        vld;
    logic        lst;
    logic        xfer;

    // First set bit of e at or after ptr, wrapping modulo 16.
    function automatic logic [3:0] rr_pick(input logic [15:0] e, input logic [3:0] ptr);
        logic [3:0] idx;
        logic [3:0] win;
        logic       found;
        win   = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < 16; k++) begin
            idx = ptr + 4'(k);
            if (!found && e[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    assign elig     = req_valid_i & req_mask_i;
    assign elig_rel = elig & ~(16'd1 << g_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            g_q     <= '0;
            p_q     <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            p_q     <= p_d;
            c_q     <= c_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        p_d         = p_q;
        c_d         = c_q;
        req_ready_o = '0;
        vld         = 1'b0;
        lst         = 1'b0;
        xfer        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|elig) begin
                    state_d = GRANT;
                    g_d     = rr_pick(elig, p_q);
                    c_d     = '0;
                end
            end
            GRANT: begin
                vld              = req_valid_i[g_q];
                lst              = vld & (req_last_i[g_q] | (c_q == LAST_BEAT));
                req_ready_o[g_q] = out_ready_i;
                xfer             = vld & out_ready_i;
                if (xfer) begin
                    if (lst) begin
                        // Releasing requester is excluded so it cannot win back-to-back.
                        p_d = g_q + 4'd1;
                        c_d = '0;
                        if (|elig_rel) begin
                            g_d = rr_pick(elig_rel, g_q + 4'd1);
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        c_d = c_q + 8'd1;
                    end
                end
            end
        endcase
    end

    assign sel_o       = g_q;
    assign out_valid_o = vld;
    assign out_last_o  = lst;
    assign busy_o      = (state_q == GRANT);

endmodule

// File: tb/tb_rr_arb_16x1.sv
// Self-checking bench for rr_arb_16x1: vector tables, directed corner sequences
// and randomized traffic against a round-robin reference model.
module tb_rr_arb_16x1;

    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] v = '0;
    logic [15:0] l = '0;
    logic [15:0] m = '0;
    logic        r = 1'b0;
    logic [15:0] req_ready;
    logic [3:0]  sel;
    logic        out_valid;
    logic        out_last;
    logic        busy;

    int checks = 0;
    int failures = 0;

    bit m_grant;
    int m_g, m_p, m_c;

    typedef struct {
        logic [15:0] v, l, m;
        logic        r;
        logic [3:0]  sel;
        logic        busy;
        logic [15:0] rdy;
        logic        ov, ol;
    } vec_t;

    vec_t tab_all[$];
    vec_t tab_wrap[$];

    rr_arb_16x1 #(.MAX_BEATS(MB), .W(32)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (v),
        .req_last_i  (l),
        .req_mask_i  (m),
        .out_ready_i (r),
        .req_ready_o (req_ready),
        .sel_o       (sel),
        .out_valid_o (out_valid),
        .out_last_o  (out_last),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [15:0] e, input int ptr);
        for (int k = 0; k < 16; k++) begin
            if (e[(ptr + k) % 16]) return (ptr + k) % 16;
        end
        return ptr;
    endfunction

    task automatic model_reset();
        m_grant = 0; m_g = 0; m_p = 0; m_c = 0;
    endtask

    task automatic check_model();
        logic        ov;
        logic [15:0] rd;
        ov = m_grant && v[m_g];
        rd = (m_grant && r) ? (16'd1 << m_g) : 16'd0;
        check("m_busy", busy, m_grant);
        check("m_sel", sel, m_g);
        check("m_ready", req_ready, rd);
        check("m_ovalid", out_valid, ov);
        check("m_olast", out_last, ov && (l[m_g] || m_c == MB - 1));
    endtask

    task automatic model_step();
        logic [15:0] e, e2;
        e = v & m;
        if (!m_grant) begin
            if (e != 0) begin
                m_grant = 1; m_g = pick(e, m_p); m_c = 0;
            end
        end else if (v[m_g] && r) begin
            if (l[m_g] || m_c == MB - 1) begin
                m_p = (m_g + 1) % 16;
                e2 = e;
                e2[m_g] = 1'b0;
                m_c = 0;
                if (e2 != 0) m_g = pick(e2, m_p);
                else m_grant = 0;
            end else begin
                m_c++;
            end
        end
    endtask

    task automatic apply(input logic [15:0] vv, input logic [15:0] ll,
                         input logic [15:0] mm, input logic rr);
        @(negedge clk);
        v = vv; l = ll; m = mm; r = rr;
        #2;
        check_model();
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_sel", sel, 4'd0);
        check("rst_ready", req_ready, 16'd0);
        check("rst_ovalid", out_valid, 1'b0);
        check("rst_olast", out_last, 1'b0);
        v = '0; l = '0; m = '0; r = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_vecs(input string name, input vec_t tv[$]);
        foreach (tv[i]) begin
            apply(tv[i].v, tv[i].l, tv[i].m, tv[i].r);
            check({name, "_sel"}, sel, tv[i].sel);
            check({name, "_busy"}, busy, tv[i].busy);
            check({name, "_ready"}, req_ready, tv[i].rdy);
            check({name, "_ovalid"}, out_valid, tv[i].ov);
            check({name, "_olast"}, out_last, tv[i].ol);
            tick();
        end
    endtask

    initial begin
        int xfers;
        int cyc;
        logic [15:0] vv, ll, mm;

        // All requesters with single-beat bursts: IDLE, then grants 0..15, 0.
        tab_all.push_back('{16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 4'd0, 1'b0, 16'h0, 1'b0, 1'b0});
        for (int k = 0; k < 17; k++) begin
            logic [3:0] gi;
            gi = 4'(k % 16);
            tab_all.push_back('{16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, gi, 1'b1, 16'd1 << gi, 1'b1, 1'b1});
        end
        // Mask 8001: alternation 0, 15, 0, 15 with pointer wrap.
        tab_wrap.push_back('{16'hFFFF, 16'hFFFF, 16'h8001, 1'b1, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b0});
        tab_wrap.push_back('{16'hFFFF, 16'hFFFF, 16'h8001, 1'b1, 4'd0, 1'b1, 16'h0001, 1'b1, 1'b1});
        tab_wrap.push_back('{16'hFFFF, 16'hFFFF, 16'h8001, 1'b1, 4'd15, 1'b1, 16'h8000, 1'b1, 1'b1});
        tab_wrap.push_back('{16'hFFFF, 16'hFFFF, 16'h8001, 1'b1, 4'd0, 1'b1, 16'h0001, 1'b1, 1'b1});
        tab_wrap.push_back('{16'hFFFF, 16'hFFFF, 16'h8001, 1'b1, 4'd15, 1'b1, 16'h8000, 1'b1, 1'b1});

        #1;
        do_reset();

        // Idle with no requests.
        for (int k = 0; k < 10; k++) begin
            apply(16'h0000, 16'h0000, 16'hFFFF, 1'b1);
            check("idle_busy", busy, 1'b0);
            check("idle_ready", req_ready, 16'd0);
            check("idle_sel", sel, 4'd0);
            tick();
        end

        do_reset();
        run_vecs("all", tab_all);
        do_reset();
        run_vecs("wrap", tab_wrap);

        // Requester 5, 4-beat burst with out_ready toggling.
        do_reset();
        xfers = 0;
        for (cyc = 0; cyc < 40 && xfers < 4; cyc++) begin
            apply(16'h0020, (xfers == 3) ? 16'h0020 : 16'h0000, 16'hFFFF, (cyc % 2) == 0);
            if (out_valid && req_ready[5]) begin
                xfers++;
                check("r5_last", out_last, xfers == 4);
            end
            tick();
        end
        check("r5_xfers", xfers, 4);
        apply(16'h0000, 16'h0000, 16'hFFFF, 1'b1);
        check("r5_busy_drop", busy, 1'b0);
        tick();
        apply(16'h0090, 16'h0090, 16'hFFFF, 1'b1);
        tick();
        apply(16'h0090, 16'h0090, 16'hFFFF, 1'b0);
        check("r5_ptr6_sel", sel, 4'd7);
        tick();

        // Forced release after MB beats, hand-over to 7 in the same cycle.
        do_reset();
        xfers = 0;
        for (cyc = 0; cyc < 20 && xfers < MB; cyc++) begin
            apply(16'h0088, 16'h0000, 16'hFFFF, 1'b1);
            if (out_valid && req_ready[3]) begin
                xfers++;
                check("force_last", out_last, xfers == MB);
            end
            tick();
        end
        check("force_xfers", xfers, MB);
        apply(16'h0088, 16'h0000, 16'hFFFF, 1'b0);
        check("force_next_sel", sel, 4'd7);
        check("force_next_busy", busy, 1'b1);
        tick();

        // Reset mid-burst on 9, then 2 wins from pointer 0.
        do_reset();
        apply(16'h0200, 16'h0000, 16'hFFFF, 1'b1);
        tick();
        apply(16'h0200, 16'h0000, 16'hFFFF, 1'b1);
        check("mid_sel9", sel, 4'd9);
        tick();
        apply(16'h0200, 16'h0000, 16'hFFFF, 1'b1);
        do_reset();
        apply(16'h0204, 16'h0000, 16'hFFFF, 1'b1);
        tick();
        apply(16'h0204, 16'h0000, 16'hFFFF, 1'b1);
        check("post_rst_sel2", sel, 4'd2);
        tick();

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            vv = 16'($urandom) | 16'($urandom);
            ll = 16'($urandom) & 16'($urandom);
            mm = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFFF;
            apply(vv, ll, mm, $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
